// File: rtl/fc_l1a_arbiter_if.sv
// Fast-control L1A arbiter bus.
// Carries every non-clock, non-reset signal of fc_l1a_arbiter.
//   master : trigger sources, configuration and status inputs -> arbiter
//            (also observes the arbiter outputs)
//   slave  : the arbiter; drives l1a_out, l1a_src, counters and veto_status
interface fc_l1a_arbiter_if #(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned PS_W    = 8,
    parameter int unsigned DT_W    = 12,
    parameter int unsigned OCC_W   = 8,
    parameter int unsigned MAX_WIN = 64,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned WL_W = $clog2(MAX_WIN) + 1;

    logic [N_SRC-1:0]      trig_in;
    logic [N_SRC-1:0]      src_enable;
    logic [N_SRC*PS_W-1:0] src_prescale;
    logic [DT_W-1:0]       deadtime;
    logic                  busy_in;
    logic                  veto_busy_en;
    logic [OCC_W-1:0]      occupancy;
    logic [OCC_W-1:0]      occ_busy_thr;
    logic [OCC_W-1:0]      occ_ready_thr;
    logic                  veto_occ_en;
    logic [WL_W-1:0]       window_len;
    logic [7:0]            window_max;
    logic                  clear_counters;
    logic                  l1a_out;
    logic [N_SRC-1:0]      l1a_src;
    logic [CNT_W-1:0]      accepted_count;
    logic [CNT_W-1:0]      vetoed_count;
    logic [3:0]            veto_status;

    modport master (
        output trig_in, src_enable, src_prescale, deadtime, busy_in, veto_busy_en,
               occupancy, occ_busy_thr, occ_ready_thr, veto_occ_en, window_len,
               window_max, clear_counters,
        input  l1a_out, l1a_src, accepted_count, vetoed_count, veto_status
    );

    modport slave (
        input  trig_in, src_enable, src_prescale, deadtime, busy_in, veto_busy_en,
               occupancy, occ_busy_thr, occ_ready_thr, veto_occ_en, window_len,
               window_max, clear_counters,
        output l1a_out, l1a_src, accepted_count, vetoed_count, veto_status
    );
endinterface

// File: rtl/fc_l1a_arbiter.sv
// Fast-control L1A arbiter (clk_bx domain).
// Merges N_SRC trigger sources through per-source enables and prescalers into one
// L1A request, applies deadtime / DAQ-busy / occupancy-hysteresis / sliding-window
// vetoes, and registers the accepted L1A with its source mask.
// Ports:
//   clk_bx  : bunch clock, the only clock
//   reset_n : asynchronous active-low reset
//   bus     : fc_l1a_arbiter_if.slave (triggers, configuration, L1A, counters, status)
module fc_l1a_arbiter #(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned PS_W    = 8,
    parameter int unsigned DT_W    = 12,
    parameter int unsigned OCC_W   = 8,
    parameter int unsigned MAX_WIN = 64,
    parameter int unsigned CNT_W   = 16
) (
    input logic              clk_bx,
    input logic              reset_n,
    fc_l1a_arbiter_if.slave  bus
);
    localparam int unsigned WL_W = $clog2(MAX_WIN) + 1;
    // Window count must hold 0..MAX_WIN inclusive.
    localparam int unsigned WC_W = $clog2(MAX_WIN + 1);

    logic [N_SRC-1:0][PS_W-1:0] pc_q, pc_d;
    logic [N_SRC-1:0][PS_W-1:0] ps_lim;
    logic [N_SRC-1:0]           pass;
    logic [DT_W-1:0]            dt_cnt_q, dt_cnt_d;
    logic                       occ_busy_q, occ_busy_d;
    logic [MAX_WIN-1:0]         hist_q, hist_d;
    logic [WC_W-1:0]            win_cnt_q, win_cnt_d;
    logic                       win_old;
    logic                       l1a_out_q;
    logic [N_SRC-1:0]           l1a_src_q;
    logic [CNT_W-1:0]           acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]           veto_cnt_q, veto_cnt_d;
    logic [3:0]                 veto_status_q;
    logic                       req, veto, accept;
    logic                       t_dt, t_busy, t_occ, t_win;

    // Prescalers: a raw trigger passes once the counter reaches P-1 (P=0 acts as 1).
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            ps_lim[i] = (bus.src_prescale[i*PS_W +: PS_W] == '0) ? '0 :
                        bus.src_prescale[i*PS_W +: PS_W] - PS_W'(1);
            pc_d[i]   = pc_q[i];
            pass[i]   = 1'b0;
            if (bus.trig_in[i] && bus.src_enable[i]) begin
                if (pc_q[i] >= ps_lim[i]) begin
                    pass[i] = 1'b1;
                    pc_d[i] = '0;
                end else begin
                    pc_d[i] = pc_q[i] + PS_W'(1);
                end
            end
        end
    end

    // Oldest accept still inside the window; out-of-range lengths fall back to hist[0].
    always_comb begin
        win_old = hist_q[0];
        for (int k = 0; k < MAX_WIN; k++) begin
            if (bus.window_len == WL_W'(k + 1)) win_old = hist_q[k];
        end
    end

    always_comb begin
        t_dt   = (dt_cnt_q != '0);
        t_busy = bus.busy_in & bus.veto_busy_en;
        t_occ  = occ_busy_q & bus.veto_occ_en;
        t_win  = (bus.window_max != 8'd0) && (32'(win_cnt_q) >= 32'(bus.window_max));
        veto   = t_dt | t_busy | t_occ | t_win;
        req    = |pass;
        accept = req & ~veto;
    end

    always_comb begin
        if (accept) begin
            dt_cnt_d = bus.deadtime;
        end else if (dt_cnt_q != '0) begin
            dt_cnt_d = dt_cnt_q - DT_W'(1);
        end else begin
            dt_cnt_d = dt_cnt_q;
        end

        // Set threshold wins over clear threshold.
        if (bus.occupancy >= bus.occ_busy_thr) begin
            occ_busy_d = 1'b1;
        end else if (bus.occupancy <= bus.occ_ready_thr) begin
            occ_busy_d = 1'b0;
        end else begin
            occ_busy_d = occ_busy_q;
        end

        hist_d    = {hist_q[MAX_WIN-2:0], accept};
        win_cnt_d = win_cnt_q + WC_W'(accept) - WC_W'(win_old);

        acc_cnt_d  = acc_cnt_q;
        veto_cnt_d = veto_cnt_q;
        if (bus.clear_counters) begin
            acc_cnt_d  = '0;
            veto_cnt_d = '0;
        end else begin
            if (accept && (acc_cnt_q != '1)) acc_cnt_d = acc_cnt_q + CNT_W'(1);
            if (req && veto && (veto_cnt_q != '1)) veto_cnt_d = veto_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_bx or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= '0;
            dt_cnt_q      <= '0;
            occ_busy_q    <= 1'b0;
            hist_q        <= '0;
            win_cnt_q     <= '0;
            l1a_out_q     <= 1'b0;
            l1a_src_q     <= '0;
            acc_cnt_q     <= '0;
            veto_cnt_q    <= '0;
            veto_status_q <= '0;
        end else begin
            pc_q          <= pc_d;
            dt_cnt_q      <= dt_cnt_d;
            occ_busy_q    <= occ_busy_d;
            hist_q        <= hist_d;
            win_cnt_q     <= win_cnt_d;
            l1a_out_q     <= accept;
            l1a_src_q     <= accept ? pass : '0;
            acc_cnt_q     <= acc_cnt_d;
            veto_cnt_q    <= veto_cnt_d;
            veto_status_q <= {t_win, t_occ, t_busy, t_dt};
        end
    end

    assign bus.l1a_out        = l1a_out_q;
    assign bus.l1a_src        = l1a_src_q;
    assign bus.accepted_count = acc_cnt_q;
    assign bus.vetoed_count   = veto_cnt_q;
    assign bus.veto_status    = veto_status_q;
endmodule

// File: tb/tb_fc_l1a_arbiter.sv
// Bench for fc_l1a_arbiter: directed phases plus a randomized phase, every cycle
// compared against a behavioural model built from accept timestamps and plain counts.
module tb_fc_l1a_arbiter;
    localparam int unsigned N_SRC   = 4;
    localparam int unsigned PS_W    = 8;
    localparam int unsigned DT_W    = 12;
    localparam int unsigned OCC_W   = 8;
    localparam int unsigned MAX_WIN = 64;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned WL_W    = $clog2(MAX_WIN) + 1;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk_bx  = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_bx = ~clk_bx;

    fc_l1a_arbiter_if #(
        .N_SRC(N_SRC), .PS_W(PS_W), .DT_W(DT_W), .OCC_W(OCC_W),
        .MAX_WIN(MAX_WIN), .CNT_W(CNT_W)
    ) bus ();

    fc_l1a_arbiter #(
        .N_SRC(N_SRC), .PS_W(PS_W), .DT_W(DT_W), .OCC_W(OCC_W),
        .MAX_WIN(MAX_WIN), .CNT_W(CNT_W)
    ) dut (
        .clk_bx (clk_bx),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int             cyc = 0;
    int             seen [N_SRC];       // enabled triggers since the last pass
    bit             have_acc;
    int             last_acc;
    int             last_dt;
    int             acc_hist[$];        // cycle numbers of accepted L1As
    bit             m_occ_busy;
    int             m_acc, m_veto;
    bit             e_l1a;
    bit [N_SRC-1:0] e_src;
    bit [3:0]       e_vs;

    task automatic model_reset();
        for (int i = 0; i < N_SRC; i++) seen[i] = 0;
        have_acc   = 1'b0;
        acc_hist.delete();
        m_occ_busy = 1'b0;
        m_acc      = 0;
        m_veto     = 0;
        e_l1a      = 1'b0;
        e_src      = '0;
        e_vs       = '0;
    endtask

    task automatic model_step();
        bit [N_SRC-1:0] pass;
        int  p, win_n;
        bit  t_dt, t_busy, t_occ, t_win, req, acc;
        pass = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (bus.trig_in[i] && bus.src_enable[i]) begin
                p = int'(bus.src_prescale[i*PS_W +: PS_W]);
                if (p == 0) p = 1;
                seen[i]++;
                if (seen[i] >= p) begin
                    pass[i] = 1'b1;
                    seen[i] = 0;
                end
            end
        end
        // An accept at cycle a blocks cycles a+1 .. a+deadtime.
        t_dt   = have_acc && ((cyc - last_acc) <= last_dt);
        t_busy = bus.busy_in && bus.veto_busy_en;
        t_occ  = m_occ_busy && bus.veto_occ_en;
        // Accepts in the window_len cycles preceding this one.
        win_n = 0;
        foreach (acc_hist[k]) if (acc_hist[k] >= cyc - int'(bus.window_len)) win_n++;
        t_win = (bus.window_max != 0) && (win_n >= int'(bus.window_max));
        req   = |pass;
        acc   = req && !(t_dt || t_busy || t_occ || t_win);
        if (acc) begin
            have_acc = 1'b1;
            last_acc = cyc;
            last_dt  = int'(bus.deadtime);
            acc_hist.push_back(cyc);
        end
        while (acc_hist.size() > 0 && acc_hist[0] < cyc - int'(MAX_WIN)) acc_hist.pop_front();
        if (bus.clear_counters) begin
            m_acc  = 0;
            m_veto = 0;
        end else begin
            if (acc && m_acc < CNT_MAX) m_acc++;
            if (req && !acc && m_veto < CNT_MAX) m_veto++;
        end
        if (bus.occupancy >= bus.occ_busy_thr) m_occ_busy = 1'b1;
        else if (bus.occupancy <= bus.occ_ready_thr) m_occ_busy = 1'b0;
        e_l1a = acc;
        e_src = acc ? pass : '0;
        e_vs  = {t_win, t_occ, t_busy, t_dt};
        cyc++;
    endtask

    // One clock: model the inputs now on the bus, clock, then compare just after the edge.
    task automatic step();
        model_step();
        @(posedge clk_bx);
        #1;
        check_val("l1a_out", bus.l1a_out, e_l1a);
        check_val("l1a_src", bus.l1a_src, e_src);
        check_val("accepted_count", bus.accepted_count, m_acc);
        check_val("vetoed_count", bus.vetoed_count, m_veto);
        check_val("veto_status", bus.veto_status, e_vs);
    endtask

    task automatic idle(input int n);
        bus.trig_in = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_l1a_out"}, bus.l1a_out, 0);
        check_val({tag, "_l1a_src"}, bus.l1a_src, 0);
        check_val({tag, "_accepted"}, bus.accepted_count, 0);
        check_val({tag, "_vetoed"}, bus.vetoed_count, 0);
        check_val({tag, "_veto_status"}, bus.veto_status, 0);
    endtask

    initial begin
        bus.trig_in        = '0;
        bus.src_enable     = '0;
        bus.src_prescale   = '0;
        bus.deadtime       = '0;
        bus.busy_in        = 1'b0;
        bus.veto_busy_en   = 1'b0;
        bus.occupancy      = '0;
        bus.occ_busy_thr   = 8'd255;
        bus.occ_ready_thr  = 8'd0;
        bus.veto_occ_en    = 1'b0;
        bus.window_len     = WL_W'(1);
        bus.window_max     = 8'd0;
        bus.clear_counters = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk_bx);
        #1;
        check_all_zero("reset");
        @(negedge clk_bx);
        reset_n = 1'b1;
        idle(2);

        // Prescale 3 on source 0: pulses 3, 6, 9 pass
        bus.src_enable                = 4'b0001;
        bus.src_prescale[0*PS_W +: PS_W] = 8'd3;
        for (int k = 0; k < 9; k++) begin
            bus.trig_in = 4'b0001;
            step();
            check_val("ps_pulse_l1a", bus.l1a_out, ((k % 3) == 2));
            bus.trig_in = '0;
            step();
        end
        check_val("ps_accepted", bus.accepted_count, 3);

        bus.clear_counters = 1'b1;
        step();
        bus.clear_counters = 1'b0;

        // Deadtime 5 on continuous source 1; vetoed count saturates at 15
        bus.src_enable                = 4'b0010;
        bus.src_prescale[1*PS_W +: PS_W] = 8'd1;
        bus.deadtime                  = DT_W'(5);
        bus.trig_in                   = 4'b0010;
        for (int k = 0; k < 24; k++) begin
            step();
            check_val("dt_spacing", bus.l1a_out, ((k % 6) == 0));
        end
        check_val("dt_accepted", bus.accepted_count, 4);
        check_val("dt_vetoed_sat", bus.vetoed_count, 15);

        // Asynchronous reset while l1a_out is high and deadtime is running
        step();
        check_val("pre_rst_l1a", bus.l1a_out, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk_bx);
        reset_n = 1'b1;
        step();
        check_val("first_after_rst", bus.l1a_out, 1);
        idle(8);

        // Simultaneous sources 1 and 3 (prescale 1 and 0)
        bus.src_enable                = 4'b1111;
        bus.deadtime                  = '0;
        bus.src_prescale[3*PS_W +: PS_W] = 8'd0;
        bus.trig_in                   = 4'b1010;
        step();
        check_val("simul_src", bus.l1a_src, 4'b1010);
        idle(2);

        // Occupancy hysteresis with continuous triggers on source 1
        bus.occ_busy_thr  = 8'd3;
        bus.occ_ready_thr = 8'd1;
        bus.veto_occ_en   = 1'b1;
        bus.trig_in       = 4'b0010;
        for (int k = 0; k < 16; k++) begin
            case (k / 2)
                0: bus.occupancy = 8'd0;
                1: bus.occupancy = 8'd1;
                2: bus.occupancy = 8'd2;
                3: bus.occupancy = 8'd3;
                4: bus.occupancy = 8'd4;
                5: bus.occupancy = 8'd2;
                6: bus.occupancy = 8'd1;
                default: bus.occupancy = 8'd0;
            endcase
            step();
        end
        bus.veto_occ_en  = 1'b0;
        bus.occupancy    = '0;
        bus.occ_busy_thr = 8'd255;
        idle(2);

        // Sliding window: len 10, max 2, deadtime 0, continuous triggers
        idle(MAX_WIN + 2);
        bus.window_len = WL_W'(10);
        bus.window_max = 8'd2;
        bus.trig_in    = 4'b0010;
        for (int k = 0; k < 34; k++) step();
        bus.window_max = 8'd0;

        // Randomized phase (window_len fixed after a quiet period)
        idle(MAX_WIN + 2);
        bus.window_len    = WL_W'($urandom_range(1, MAX_WIN));
        bus.occ_busy_thr  = 8'd5;
        bus.occ_ready_thr = 8'd2;
        for (int k = 0; k < 500; k++) begin
            bus.trig_in        = 4'($urandom);
            bus.src_enable     = 4'($urandom) | 4'($urandom);
            for (int i = 0; i < N_SRC; i++)
                bus.src_prescale[i*PS_W +: PS_W] = PS_W'($urandom_range(0, 3));
            bus.deadtime       = DT_W'($urandom_range(0, 4));
            bus.busy_in        = ($urandom_range(0, 7) == 0);
            bus.veto_busy_en   = 1'($urandom);
            bus.occupancy      = OCC_W'($urandom_range(0, 7));
            bus.veto_occ_en    = 1'($urandom);
            bus.window_max     = 8'($urandom_range(0, 4));
            bus.clear_counters = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
